// File: rtl/atomic_crack_seq_if.sv
// Decode-side bundle for the atomic cracking sequencer: fetch controls in,
// micro-op tags, backpressure and status out.
interface atomic_crack_seq_if #(
    parameter int CNT_W = 32
);
    logic             halt;
    logic             flush;
    logic             exec_stall;
    logic             bubble_in;
    logic [4:0]       opcode;
    logic [1:0]       uop_kind;
    logic [1:0]       atomic_step;
    logic             is_atomic;
    logic             is_fetch_add;
    logic             decode_stall;
    logic             seq_done;
    logic             protocol_err;
    logic [CNT_W-1:0] atomic_count;

    modport master (
        output halt, flush, exec_stall, bubble_in, opcode,
        input  uop_kind, atomic_step, is_atomic, is_fetch_add, decode_stall,
               seq_done, protocol_err, atomic_count
    );

    modport slave (
        input  halt, flush, exec_stall, bubble_in, opcode,
        output uop_kind, atomic_step, is_atomic, is_fetch_add, decode_stall,
               seq_done, protocol_err, atomic_count
    );
endinterface

// File: rtl/atomic_crack_seq.sv
// Cracks swap (load, store) and fetch_add (load, add, store) into micro-ops,
// holding decode while steps remain and counting completed sequences.
module atomic_crack_seq #(
    parameter logic [4:0] OP_FADD_LO = 5'd16,
    parameter logic [4:0] OP_FADD_HI = 5'd18,
    parameter logic [4:0] OP_SWAP_LO = 5'd19,
    parameter logic [4:0] OP_SWAP_HI = 5'd21,
    parameter int         CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    atomic_crack_seq_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, S_ADD, S_ST} state_t;
    typedef enum logic [1:0] {UOP_PASS, UOP_LOAD, UOP_ADD, UOP_STORE} uop_t;

    state_t           state;
    logic             seq_fa;
    logic             seq_done_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    logic fa;
    logic sw;
    logic valid;
    logic type_match;
    uop_t uop;
    logic [1:0] step;
    logic atomic;
    logic stall;

    assign fa         = (bus.opcode >= OP_FADD_LO) && (bus.opcode <= OP_FADD_HI);
    assign sw         = (bus.opcode >= OP_SWAP_LO) && (bus.opcode <= OP_SWAP_HI);
    assign valid      = !bus.bubble_in;
    // The store step must see the same atomic flavour that started the sequence.
    assign type_match = seq_fa ? fa : sw;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        uop    = UOP_PASS;
        step   = 2'd0;
        atomic = 1'b0;
        stall  = 1'b0;
        if (valid) begin
            case (state)
                IDLE: begin
                    if (fa || sw) begin
                        uop    = UOP_LOAD;
                        atomic = 1'b1;
                        stall  = 1'b1;
                    end
                end
                S_ADD: begin
                    if (fa) begin
                        uop    = UOP_ADD;
                        step   = 2'd1;
                        atomic = 1'b1;
                        stall  = 1'b1;
                    end
                end
                S_ST: begin
                    if (type_match) begin
                        uop    = UOP_STORE;
                        step   = fa ? 2'd2 : 2'd1;
                        atomic = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.uop_kind     = uop;
    assign bus.atomic_step  = step;
    assign bus.is_atomic    = atomic;
    assign bus.is_fetch_add = fa && atomic;
    assign bus.decode_stall = stall;
    assign bus.seq_done     = seq_done_q;
    assign bus.protocol_err = err_q;
    assign bus.atomic_count = count_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            seq_fa     <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else if (!bus.halt) begin
            seq_done_q <= 1'b0;
            if (!bus.exec_stall) begin
                if (bus.flush || !valid) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            if (fa) begin
                                state  <= S_ADD;
                                seq_fa <= 1'b1;
                            end else if (sw) begin
                                state  <= S_ST;
                                seq_fa <= 1'b0;
                            end
                        end
                        S_ADD: begin
                            if (fa) begin
                                state <= S_ST;
                            end else begin
                                state <= IDLE;
                                err_q <= 1'b1;
                            end
                        end
                        S_ST: begin
                            state <= IDLE;
                            if (type_match) begin
                                seq_done_q <= 1'b1;
                                count_q    <= count_q + 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
